// File: rtl/multi_channel_fifo_pkg.sv
// Shared constants, per-channel status record and slice helper for the
// multi-channel FIFO controller.
package multi_channel_fifo_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_DEPTH    = 4;
  localparam int DEFAULT_CHANNELS = 4;

  // Wide enough for any practical per-channel occupancy.
  localparam int STATUS_LEVEL_W = 16;

  typedef struct packed {
    logic                      empty;
    logic                      full;
    logic [STATUS_LEVEL_W-1:0] level;
  } channel_status_t;

  // LSB of channel c inside a flattened level/space bus.
  function automatic int level_lsb(input int channel, input int depth_log2);
    return channel * (depth_log2 + 1);
  endfunction

endpackage

// File: rtl/multi_channel_fifo_controller_pointers.sv
// Per-channel pointer pair with lap bits, flush load, occupancy and flags.
// Also holds the wrapping counter used for both pointers.
module advanced_wrapping_counter #(
  parameter int RANGE   = 4,
  parameter int LAP_BIT = 1,
  parameter int COUNT_W = $clog2(RANGE)
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       load_enable,
  input  logic [COUNT_W+LAP_BIT-1:0] load_value,
  input  logic                       increment,
  output logic [COUNT_W+LAP_BIT-1:0] count
);

  localparam int TW = COUNT_W + LAP_BIT;

  logic [TW-1:0] count_q, count_d;

  // Load wins over increment; the local part wraps at RANGE-1 and bumps the lap.
  always_comb begin
    count_d = count_q;
    if (load_enable) begin
      count_d = load_value;
    end else if (increment) begin
      if (count_q[COUNT_W-1:0] == COUNT_W'(RANGE - 1)) begin
        count_d[COUNT_W-1:0]  = '0;
        count_d[TW-1:COUNT_W] = count_q[TW-1:COUNT_W] + LAP_BIT'(1);
      end else begin
        count_d = count_q + TW'(1);
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

module fifo_channel_pointers #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = $clog2(DEPTH),
  parameter int LW         = DEPTH_LOG2 + 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  write_advance,
  input  logic                  read_advance,
  input  logic [LW-1:0]         lower_threshold_level,
  input  logic [LW-1:0]         upper_threshold_level,
  output logic [DEPTH_LOG2-1:0] write_address,
  output logic [DEPTH_LOG2-1:0] read_address,
  output logic                  empty,
  output logic                  full,
  output logic [LW-1:0]         level,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  half_empty,
  output logic                  half_full,
  output logic                  lower_threshold_status,
  output logic                  upper_threshold_status
);

  logic [LW-1:0] write_pointer, read_pointer;
  logic [LW-1:0] space_w;
  logic          same_lap;

  advanced_wrapping_counter #(.RANGE(DEPTH), .LAP_BIT(1), .COUNT_W(DEPTH_LOG2)) u_write_ptr (
    .clock       (clock),
    .resetn      (resetn),
    .load_enable (1'b0),
    .load_value  ('0),
    .increment   (write_advance),
    .count       (write_pointer)
  );

  // Flush snaps the read pointer onto the write pointer, emptying the queue.
  advanced_wrapping_counter #(.RANGE(DEPTH), .LAP_BIT(1), .COUNT_W(DEPTH_LOG2)) u_read_ptr (
    .clock       (clock),
    .resetn      (resetn),
    .load_enable (flush),
    .load_value  (write_pointer),
    .increment   (read_advance),
    .count       (read_pointer)
  );

  assign write_address = write_pointer[DEPTH_LOG2-1:0];
  assign read_address  = read_pointer[DEPTH_LOG2-1:0];
  assign same_lap      = (write_pointer[DEPTH_LOG2] == read_pointer[DEPTH_LOG2]);

  assign empty = (write_address == read_address) && same_lap;
  assign full  = (write_address == read_address) && !same_lap;

  // Occupancy: differing laps mean the write pointer has wrapped past the read pointer.
  always_comb begin
    if (same_lap) begin
      level = LW'(write_address) - LW'(read_address);
    end else begin
      level = LW'(write_address) + LW'(DEPTH) - LW'(read_address);
    end
  end

  assign space_w                = LW'(DEPTH) - level;
  assign almost_empty           = (level == LW'(1));
  assign almost_full            = (space_w == LW'(1));
  assign half_empty             = (level <= LW'(DEPTH / 2));
  assign half_full              = (space_w <= LW'(DEPTH / 2));
  assign lower_threshold_status = (level <= lower_threshold_level);
  assign upper_threshold_status = (level >= upper_threshold_level);

endmodule

// File: rtl/multi_channel_fifo_controller.sv
// Multi-channel FIFO controller over one shared, statically partitioned
// memory: channel decode, address composition, error pulses, output muxing.
import multi_channel_fifo_pkg::*;

module multi_channel_fifo_controller #(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int CHANNELS      = DEFAULT_CHANNELS,
  parameter int DEPTH_LOG2    = $clog2(DEPTH),
  parameter int CHANNELS_LOG2 = $clog2(CHANNELS),
  parameter int ADDRESS_WIDTH = $clog2(CHANNELS * DEPTH)
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic [CHANNELS-1:0]                 flush,
  input  logic                                write_enable,
  input  logic [CHANNELS_LOG2-1:0]            write_channel,
  input  logic [WIDTH-1:0]                    write_data,
  input  logic                                read_enable,
  input  logic [CHANNELS_LOG2-1:0]            read_channel,
  output logic [WIDTH-1:0]                    read_data,
  output logic [CHANNELS-1:0]                 empty,
  output logic [CHANNELS-1:0]                 not_empty,
  output logic [CHANNELS-1:0]                 almost_empty,
  output logic [CHANNELS-1:0]                 half_empty,
  output logic [CHANNELS-1:0]                 full,
  output logic [CHANNELS-1:0]                 not_full,
  output logic [CHANNELS-1:0]                 almost_full,
  output logic [CHANNELS-1:0]                 half_full,
  output logic                                write_miss,
  output logic                                read_error,
  output logic [CHANNELS*(DEPTH_LOG2+1)-1:0]  level,
  output logic [CHANNELS*(DEPTH_LOG2+1)-1:0]  space,
  input  logic [DEPTH_LOG2:0]                 lower_threshold_level,
  input  logic [DEPTH_LOG2:0]                 upper_threshold_level,
  output logic [CHANNELS-1:0]                 lower_threshold_status,
  output logic [CHANNELS-1:0]                 upper_threshold_status,
  output logic                                memory_clock,
  output logic                                memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0]            memory_write_address,
  output logic [WIDTH-1:0]                    memory_write_data,
  output logic                                memory_read_enable,
  output logic [ADDRESS_WIDTH-1:0]            memory_read_address,
  input  logic [WIDTH-1:0]                    memory_read_data
);

  localparam int LW     = DEPTH_LOG2 + 1;
  localparam int CH_PAD = 1 << CHANNELS_LOG2;
  localparam logic [CHANNELS_LOG2:0] CH_COUNT = (CHANNELS_LOG2 + 1)'(CHANNELS);

  channel_status_t status [CHANNELS];

  logic [DEPTH_LOG2-1:0] wr_addr [CHANNELS];
  logic [DEPTH_LOG2-1:0] rd_addr [CHANNELS];
  logic [DEPTH_LOG2-1:0] wr_addr_sel, rd_addr_sel;

  // Padded to a power of two so any channel index selects a defined bit.
  logic [CH_PAD-1:0] empty_pad, full_pad, flush_pad;

  logic wr_valid, rd_valid, do_write, do_read;
  logic write_miss_q, write_miss_d, read_error_q, read_error_d;

  assign empty_pad = CH_PAD'(empty);
  assign full_pad  = CH_PAD'(full);
  assign flush_pad = CH_PAD'(flush);

  assign wr_valid = ({1'b0, write_channel} < CH_COUNT);
  assign rd_valid = ({1'b0, read_channel} < CH_COUNT);

  assign do_write = write_enable && wr_valid && !full_pad[write_channel] && !flush_pad[write_channel];
  assign do_read  = read_enable && rd_valid && !empty_pad[read_channel] && !flush_pad[read_channel];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
    logic          ch_empty, ch_full;
    logic [LW-1:0] ch_level;

    fifo_channel_pointers #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) u_pointers (
      .clock                  (clock),
      .resetn                 (resetn),
      .flush                  (flush[c]),
      .write_advance          (do_write && (write_channel == CHANNELS_LOG2'(c))),
      .read_advance           (do_read && (read_channel == CHANNELS_LOG2'(c))),
      .lower_threshold_level  (lower_threshold_level),
      .upper_threshold_level  (upper_threshold_level),
      .write_address          (wr_addr[c]),
      .read_address           (rd_addr[c]),
      .empty                  (ch_empty),
      .full                   (ch_full),
      .level                  (ch_level),
      .almost_empty           (almost_empty[c]),
      .almost_full            (almost_full[c]),
      .half_empty             (half_empty[c]),
      .half_full              (half_full[c]),
      .lower_threshold_status (lower_threshold_status[c]),
      .upper_threshold_status (upper_threshold_status[c])
    );

    assign status[c] = {ch_empty, ch_full, STATUS_LEVEL_W'(ch_level)};

    assign empty[c]     = status[c].empty;
    assign not_empty[c] = !status[c].empty;
    assign full[c]      = status[c].full;
    assign not_full[c]  = !status[c].full;
    assign level[level_lsb(c, DEPTH_LOG2) +: LW] = status[c].level[LW-1:0];
    assign space[level_lsb(c, DEPTH_LOG2) +: LW] = LW'(STATUS_LEVEL_W'(DEPTH) - status[c].level);
  end

  // Pick the local pointer addresses of the addressed write and read channels.
  always_comb begin
    wr_addr_sel = '0;
    rd_addr_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (write_channel == CHANNELS_LOG2'(c)) wr_addr_sel = wr_addr[c];
      if (read_channel == CHANNELS_LOG2'(c))  rd_addr_sel = rd_addr[c];
    end
  end

  assign memory_clock         = clock;
  assign memory_write_enable  = do_write;
  assign memory_write_address = ADDRESS_WIDTH'(write_channel) * ADDRESS_WIDTH'(DEPTH)
                              + ADDRESS_WIDTH'(wr_addr_sel);
  assign memory_write_data    = write_data;
  assign memory_read_enable   = rd_valid && !empty_pad[read_channel];
  assign memory_read_address  = ADDRESS_WIDTH'(read_channel) * ADDRESS_WIDTH'(DEPTH)
                              + ADDRESS_WIDTH'(rd_addr_sel);
  assign read_data            = memory_read_data;

  // Rejections are reported only when the channel is not being flushed.
  always_comb begin
    write_miss_d = write_enable &&
                   (!wr_valid || (full_pad[write_channel] && !flush_pad[write_channel]));
    read_error_d = read_enable &&
                   (!rd_valid || (empty_pad[read_channel] && !flush_pad[read_channel]));
  end

  // One-cycle error pulses registered from this cycle's request.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      write_miss_q <= 1'b0;
      read_error_q <= 1'b0;
    end else begin
      write_miss_q <= write_miss_d;
      read_error_q <= read_error_d;
    end
  end

  assign write_miss = write_miss_q;
  assign read_error = read_error_q;

endmodule

// File: tb/tb_multi_channel_fifo_controller.sv
// Scoreboard bench: instance A (4 channels x 4 deep) and instance B
// (3 channels x 3 deep) share clock and reset, each with its own memory.
module tb_multi_channel_fifo_controller;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] lower_thr = 3'd1;
  logic [2:0] upper_thr = 3'd3;

  // ---------------- instance A ----------------
  logic [3:0]  a_flush;
  logic        a_we, a_re;
  logic [1:0]  a_wch, a_rch;
  logic [7:0]  a_wd, a_rdata, a_mwd, a_mrd;
  logic [3:0]  a_empty, a_nempty, a_aempty, a_hempty, a_full, a_nfull, a_afull, a_hfull;
  logic        a_wmiss, a_rerr, a_mclk, a_mwe, a_mre;
  logic [11:0] a_level, a_space;
  logic [3:0]  a_lts, a_uts;
  logic [3:0]  a_mwa, a_mra;
  logic [7:0]  a_mem [16];

  multi_channel_fifo_controller #(.WIDTH(8), .DEPTH(4), .CHANNELS(4)) dut_a (
    .clock(clk), .resetn(resetn), .flush(a_flush),
    .write_enable(a_we), .write_channel(a_wch), .write_data(a_wd),
    .read_enable(a_re), .read_channel(a_rch), .read_data(a_rdata),
    .empty(a_empty), .not_empty(a_nempty), .almost_empty(a_aempty), .half_empty(a_hempty),
    .full(a_full), .not_full(a_nfull), .almost_full(a_afull), .half_full(a_hfull),
    .write_miss(a_wmiss), .read_error(a_rerr), .level(a_level), .space(a_space),
    .lower_threshold_level(lower_thr), .upper_threshold_level(upper_thr),
    .lower_threshold_status(a_lts), .upper_threshold_status(a_uts),
    .memory_clock(a_mclk), .memory_write_enable(a_mwe), .memory_write_address(a_mwa),
    .memory_write_data(a_mwd), .memory_read_enable(a_mre), .memory_read_address(a_mra),
    .memory_read_data(a_mrd)
  );

  always @(posedge a_mclk) if (a_mwe) a_mem[a_mwa] <= a_mwd;
  assign a_mrd = a_mem[a_mra];

  // ---------------- instance B ----------------
  logic [2:0]  b_flush;
  logic        b_we, b_re;
  logic [1:0]  b_wch, b_rch;
  logic [7:0]  b_wd, b_rdata, b_mwd, b_mrd;
  logic [2:0]  b_empty, b_nempty, b_aempty, b_hempty, b_full, b_nfull, b_afull, b_hfull;
  logic        b_wmiss, b_rerr, b_mclk, b_mwe, b_mre;
  logic [8:0]  b_level, b_space;
  logic [2:0]  b_lts, b_uts;
  logic [3:0]  b_mwa, b_mra;
  logic [7:0]  b_mem [16];

  multi_channel_fifo_controller #(.WIDTH(8), .DEPTH(3), .CHANNELS(3)) dut_b (
    .clock(clk), .resetn(resetn), .flush(b_flush),
    .write_enable(b_we), .write_channel(b_wch), .write_data(b_wd),
    .read_enable(b_re), .read_channel(b_rch), .read_data(b_rdata),
    .empty(b_empty), .not_empty(b_nempty), .almost_empty(b_aempty), .half_empty(b_hempty),
    .full(b_full), .not_full(b_nfull), .almost_full(b_afull), .half_full(b_hfull),
    .write_miss(b_wmiss), .read_error(b_rerr), .level(b_level), .space(b_space),
    .lower_threshold_level(lower_thr), .upper_threshold_level(upper_thr),
    .lower_threshold_status(b_lts), .upper_threshold_status(b_uts),
    .memory_clock(b_mclk), .memory_write_enable(b_mwe), .memory_write_address(b_mwa),
    .memory_write_data(b_mwd), .memory_read_enable(b_mre), .memory_read_address(b_mra),
    .memory_read_data(b_mrd)
  );

  always @(posedge b_mclk) if (b_mwe) b_mem[b_mwa] <= b_mwd;
  assign b_mrd = b_mem[b_mra];

  // ---------------- reference model (index d*4+c) ----------------
  int q    [8][$];
  int wloc [8];
  int rloc [8];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      q[i].delete();
      wloc[i] = 0;
      rloc[i] = 0;
    end
  endtask

  // Per-channel flag/level/space/threshold checks against the model.
  task automatic check_channels(input int d, input string tag);
    int nch, dep, lv, o_lv, o_sp;
    logic o_e, o_f, o_ae, o_af, o_lt, o_ut;
    nch = d ? 3 : 4;
    dep = d ? 3 : 4;
    for (int c = 0; c < nch; c++) begin
      lv = q[d*4+c].size();
      if (d == 0) begin
        o_e = a_empty[c]; o_f = a_full[c]; o_ae = a_aempty[c]; o_af = a_afull[c];
        o_lt = a_lts[c]; o_ut = a_uts[c];
        o_lv = int'(a_level[c*3 +: 3]); o_sp = int'(a_space[c*3 +: 3]);
      end else begin
        o_e = b_empty[c]; o_f = b_full[c]; o_ae = b_aempty[c]; o_af = b_afull[c];
        o_lt = b_lts[c]; o_ut = b_uts[c];
        o_lv = int'(b_level[c*3 +: 3]); o_sp = int'(b_space[c*3 +: 3]);
      end
      check_eq($sformatf("%s %s empty[%0d]", tag, d ? "B" : "A", c), 32'(o_e), 32'(lv == 0));
      check_eq($sformatf("%s %s full[%0d]", tag, d ? "B" : "A", c), 32'(o_f), 32'(lv == dep));
      check_eq($sformatf("%s %s level[%0d]", tag, d ? "B" : "A", c), 32'(o_lv), 32'(lv));
      check_eq($sformatf("%s %s space[%0d]", tag, d ? "B" : "A", c), 32'(o_sp), 32'(dep - lv));
      check_eq($sformatf("%s %s almost_empty[%0d]", tag, d ? "B" : "A", c), 32'(o_ae), 32'(lv == 1));
      check_eq($sformatf("%s %s almost_full[%0d]", tag, d ? "B" : "A", c), 32'(o_af), 32'(dep - lv == 1));
      check_eq($sformatf("%s %s lower_thr[%0d]", tag, d ? "B" : "A", c), 32'(o_lt), 32'(lv <= 1));
      check_eq($sformatf("%s %s upper_thr[%0d]", tag, d ? "B" : "A", c), 32'(o_ut), 32'(lv >= 3));
    end
  endtask

  // One clock of stimulus on instance d; called at posedge+1.
  task automatic step(input int d, input string tag, input bit we, input int wch, input int wd,
                      input bit re, input int rch, input int fl);
    int nch, dep, wi, ri;
    bit wvalid, rvalid, wfull, rempty, flw, flr, exp_dow, exp_dor, exp_wmiss, exp_rerr;
    logic o_mwe, o_mre, o_wmiss, o_rerr;
    logic [3:0] o_mwa, o_mra;
    logic [7:0] o_mwd, o_rdata;
    nch = d ? 3 : 4;
    dep = d ? 3 : 4;
    if (d == 0) begin
      a_we = we; a_wch = 2'(wch); a_wd = 8'(wd); a_re = re; a_rch = 2'(rch); a_flush = 4'(fl);
    end else begin
      b_we = we; b_wch = 2'(wch); b_wd = 8'(wd); b_re = re; b_rch = 2'(rch); b_flush = 3'(fl);
    end
    wvalid = (wch < nch);
    rvalid = (rch < nch);
    wi = d*4 + (wvalid ? wch : 0);
    ri = d*4 + (rvalid ? rch : 0);
    wfull  = wvalid && (q[wi].size() == dep);
    rempty = rvalid && (q[ri].size() == 0);
    flw = wvalid && fl[wch];
    flr = rvalid && fl[rch];
    exp_dow   = we && wvalid && !wfull && !flw;
    exp_dor   = re && rvalid && !rempty && !flr;
    exp_wmiss = we && (!wvalid || (wfull && !flw));
    exp_rerr  = re && (!rvalid || (rempty && !flr));
    #1;
    if (d == 0) begin
      o_mwe = a_mwe; o_mwa = a_mwa; o_mwd = a_mwd; o_mre = a_mre; o_mra = a_mra; o_rdata = a_rdata;
    end else begin
      o_mwe = b_mwe; o_mwa = b_mwa; o_mwd = b_mwd; o_mre = b_mre; o_mra = b_mra; o_rdata = b_rdata;
    end
    check_eq({tag, " mem_we"}, 32'(o_mwe), 32'(exp_dow));
    if (exp_dow) begin
      check_eq({tag, " mem_waddr"}, 32'(o_mwa), 32'(wch*dep + wloc[wi]));
      check_eq({tag, " mem_wdata"}, 32'(o_mwd), 32'(wd & 8'hFF));
    end
    check_eq({tag, " mem_re"}, 32'(o_mre), 32'(rvalid && !rempty));
    if (rvalid && !rempty) begin
      check_eq({tag, " mem_raddr"}, 32'(o_mra), 32'(rch*dep + rloc[ri]));
      check_eq({tag, " read_data"}, 32'(o_rdata), 32'(q[ri][0]));
    end
    @(posedge clk);
    if (exp_dor) begin
      void'(q[ri].pop_front());
      rloc[ri] = (rloc[ri] + 1) % dep;
    end
    if (exp_dow) begin
      q[wi].push_back(wd & 8'hFF);
      wloc[wi] = (wloc[wi] + 1) % dep;
    end
    for (int c = 0; c < nch; c++) begin
      if (fl[c]) begin
        q[d*4+c].delete();
        rloc[d*4+c] = wloc[d*4+c];
      end
    end
    #1;
    o_wmiss = d ? b_wmiss : a_wmiss;
    o_rerr  = d ? b_rerr  : a_rerr;
    check_eq({tag, " write_miss"}, 32'(o_wmiss), 32'(exp_wmiss));
    check_eq({tag, " read_error"}, 32'(o_rerr), 32'(exp_rerr));
    check_channels(d, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    a_flush = '0; a_we = 0; a_wch = '0; a_wd = '0; a_re = 0; a_rch = '0;
    b_flush = '0; b_we = 0; b_wch = '0; b_wd = '0; b_re = 0; b_rch = '0;
    model_clear();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset then idle
    check_eq("reset A empty", 32'(a_empty), 32'hF);
    check_eq("reset A level", 32'(a_level), 32'h0);
    check_eq("reset A wmiss", 32'(a_wmiss), 32'h0);
    for (int i = 0; i < 2; i++) step(0, "idle", 0, 0, 0, 0, 0, 0);

    // Fill channel 1 then overflow it
    for (int i = 0; i < 5; i++) step(0, "fill ch1", 1, 1, 'hA0 + i, 0, 0, 0);

    // Channel 2: two in, two out, then underflow
    step(0, "ch2 wr", 1, 2, 'h10, 0, 0, 0);
    step(0, "ch2 wr", 1, 2, 'h11, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, "ch2 rd", 0, 0, 0, 1, 2, 0);

    // Channel 3: simultaneous push/pop at level 2, then at full
    step(0, "ch3 wr", 1, 3, 'h30, 0, 0, 0);
    step(0, "ch3 wr", 1, 3, 'h31, 0, 0, 0);
    step(0, "ch3 wr+rd", 1, 3, 'h32, 1, 3, 0);
    step(0, "ch3 wr", 1, 3, 'h33, 0, 0, 0);
    step(0, "ch3 wr", 1, 3, 'h34, 0, 0, 0);
    step(0, "ch3 full wr+rd", 1, 3, 'h35, 1, 3, 0);

    // Flush channel 0 with a write to it; channel 1 untouched
    for (int i = 0; i < 3; i++) step(0, "ch0 wr", 1, 0, 'h00 + i, 0, 0, 0);
    step(0, "ch1 rd", 0, 0, 0, 1, 1, 0);
    step(0, "flush ch0", 1, 0, 'hEE, 0, 0, 'b0001);
    step(0, "post flush wr", 1, 0, 'h07, 1, 1, 0);
    step(0, "multi flush", 0, 0, 0, 0, 0, 'b1010);
    step(0, "post flush rd", 0, 0, 0, 1, 0, 0);

    // Reset asserted mid-operation takes effect without a clock edge
    step(0, "pre reset wr", 1, 2, 'h55, 0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    check_eq("async reset A empty", 32'(a_empty), 32'hF);
    check_eq("async reset A level", 32'(a_level), 32'h0);
    check_eq("async reset A full", 32'(a_full), 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;
    model_clear();
    a_we = 0; a_re = 0; a_flush = '0;
    step(0, "after reset", 0, 0, 0, 0, 0, 0);

    // Instance B: non-power-of-2 depth, lap toggles on channel 2
    step(1, "B ch2 wr", 1, 2, 'h50, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, "B ch2 wrap", 1, 2, 'h51 + i, 1, 2, 0);
    step(1, "B ch2 wr", 1, 2, 'h60, 0, 0, 0);
    step(1, "B ch2 wr", 1, 2, 'h61, 0, 0, 0);
    step(1, "B ch2 over", 1, 2, 'h62, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, "B ch2 rd", 0, 0, 0, 1, 2, 0);
    step(1, "B bad wch", 1, 3, 'h77, 0, 0, 0);
    step(1, "B bad rch", 0, 0, 0, 1, 3, 0);
    step(1, "B ch0 wr", 1, 0, 'h80, 1, 2, 0);
    step(1, "B ch0 rd", 0, 0, 0, 1, 0, 0);
    b_we = 0; b_re = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
